mult_err_sweeper: RTL and testbench
===================================

Name: mult_err_sweeper

Overview:
- Sequencer that drives one attached 8x8 approximate multiplier (any generated DT/RC variant) through every operand pair.
- For each pair it compares the multiplier's product with the exact product. It accumulates the sum of squared error, sum of absolute error, error count and maximum absolute error.
- Sits in the characterization harness beside the multiplier under test and supplies the MSE/delay figures used to rank approximate full-adder choices.

Parameters:
- WA, 8: width of operand A.
- WB, 8: width of operand B.
- LAT, 1: cycles from operand registers to a valid mult_p; 1 = combinational multiplier; legal range 1..4.
- SQ_W, 48: width of the squared-error accumulator.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a sweep
- abort  in  1  stop the sweep and return to IDLE
- busy  out  1  high while a sweep is running
- done  out  1  one-cycle pulse when results are final
- mult_a  out  WA  registered operand A to the multiplier
- mult_b  out  WB  registered operand B to the multiplier
- mult_p  in  WA+WB  product returned by the multiplier
- sum_sq  out  SQ_W  sum of (p-exact)^2
- sum_abs  out  WA+WB+17  sum of |p-exact|
- err_cnt  out  WA+WB+1  number of pairs with p != exact
- max_abs  out  WA+WB  maximum |p-exact|

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE; busy=0, done=0; mult_a=mult_b=0; all accumulators and max_abs=0; delay pipe valid bits cleared.
- rst during a sweep has the same effect. No partial results survive.
- FSM:
  - IDLE: on start -> RUN; clear the accumulators; set mult_a=mult_b=0.
  - RUN: each cycle B increments; when B wraps, A increments. The last pair is {all ones, all ones}; then -> DRAIN.
  - DRAIN: lasts exactly LAT cycles; -> DONE.
  - DONE: done=1 for one cycle; -> IDLE.
- Latency: done is high exactly 2^(WA+WB)+LAT+1 cycles after the start-sampling edge. With defaults this is 65538.
- Exact-product pipe: the issued pair's exact product a*b and a valid bit travel through a LAT-deep shift register. mult_p is sampled when the pipe output is valid.
- Error arithmetic:
  - d = mult_p - exact, as a signed WA+WB+1-bit value.
  - |d| is added to sum_abs and d*d is added to sum_sq; err_cnt is incremented when d != 0.
  - max_abs is updated when |d| > max_abs (strict).
  - Accumulators never wrap at the default widths.
- busy is 1 in RUN and DRAIN.
- start is ignored while busy or in DONE.
- abort:
  - In RUN or DRAIN: -> IDLE on the next edge, with no done pulse. Results hold their partial values and are not valid.
  - In IDLE or DONE: no effect.
  - abort and start in the same cycle in IDLE: start wins.
- Results hold their values from DONE until the next accepted start.

Optional Feature:
- Macro: MULT_ERR_WCE_CAPTURE_EN.
- Defined: extra outputs wce_a[WA-1:0] and wce_b[WB-1:0] hold the first operand pair that set the final max_abs. They update only on a strict increase, so ties keep the earlier pair. Both reset to 0 and clear on start.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package mult_err_pkg: state enum {IDLE, RUN, DRAIN, DONE}; localparams for product width, diff width, abs-sum width and count width; function for the sweep length 2^(WA+WB).
- Sub-module mult_err_accum: takes valid, d and pair; holds the four accumulators, max_abs and the optional WCE capture; has a synchronous clear.
- The top level keeps the FSM, operand counter and exact-product pipe.

Test Plan:
- Exact multiplier attached, LAT=1 -> err_cnt=0, sum_abs=0, sum_sq=0, max_abs=0; done exactly 65538 cycles after start.
- Stub mult_p=exact+1 -> err_cnt=65536, sum_abs=65536, sum_sq=65536, max_abs=1; WCE pair (0,0).
- Stub mult_p=0 -> err_cnt=65025, max_abs=65025, sum_abs=1065369600, sum_sq=30910041702400; WCE pair (255,255).
- Stub registered with LAT=3 and exact output -> all results zero, proving pipe alignment; done at cycle 65540.
- start pulses during RUN are ignored. abort at cycle 1000 -> IDLE next cycle with no done; a new start restarts from pair (0,0) with cleared sums.
- rst asserted mid-RUN -> all outputs at reset values on the next edge; busy=0.

Source files
------------

// File: rtl/mult_err_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_err_pkg                                               |
// | Description : Shared state encodings, width helpers and sweep length for |
// |               the approximate-multiplier error sweeper.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mult_err_pkg;

  // Sequencer states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Width helpers, parameterised on the operand widths
  function automatic int prod_w(input int wa, input int wb);
    return wa + wb;
  endfunction

  // Signed difference needs one bit more than the product
  function automatic int diff_w(input int wa, input int wb);
    return wa + wb + 1;
  endfunction

  // Room for 2^(wa+wb) additions of a (wa+wb)-bit magnitude, plus headroom
  function automatic int abs_w(input int wa, input int wb);
    return wa + wb + 17;
  endfunction

  // Must be able to count every pair of the sweep
  function automatic int cnt_w(input int wa, input int wb);
    return wa + wb + 1;
  endfunction

  // Number of operand pairs visited by one sweep
  function automatic longint unsigned sweep_len(input int wa, input int wb);
    return 64'd1 << (wa + wb);
  endfunction

  // Widths for the default 8x8 configuration
  localparam int DEF_WA = 8;
  localparam int DEF_WB = 8;
  localparam int PROD_W = prod_w(DEF_WA, DEF_WB);
  localparam int DIFF_W = diff_w(DEF_WA, DEF_WB);
  localparam int ABS_W  = abs_w(DEF_WA, DEF_WB);
  localparam int CNT_W  = cnt_w(DEF_WA, DEF_WB);

endpackage
`default_nettype wire

// File: rtl/mult_err_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_err_accum                                             |
// | Description : Error statistics for the sweeper: sum of squared error,    |
// |               sum of absolute error, error count and max |error|.        |
// |               MULT_ERR_WCE_CAPTURE_EN adds capture of the operand pair   |
// |               that first reached the final max |error|.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mult_err_accum
  import mult_err_pkg::*;
#(
  parameter int WA   = 8,
  parameter int WB   = 8,
  parameter int SQ_W = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    valid,
  input  logic signed [WA+WB:0]   d,
`ifdef MULT_ERR_WCE_CAPTURE_EN
  input  logic [WA-1:0]           pair_a,
  input  logic [WB-1:0]           pair_b,
  output logic [WA-1:0]           wce_a,
  output logic [WB-1:0]           wce_b,
`endif
  output logic [SQ_W-1:0]         sum_sq,
  output logic [WA+WB+16:0]       sum_abs,
  output logic [WA+WB:0]          err_cnt,
  output logic [WA+WB-1:0]        max_abs
);

  localparam int PW = prod_w(WA, WB);
  localparam int DW = diff_w(WA, WB);
  localparam int AW = abs_w(WA, WB);
  localparam int CW = cnt_w(WA, WB);

  logic [DW-1:0]   neg_w;
  logic [DW-1:0]   mag_w;
  logic [SQ_W-1:0] mag_ext_w;
  logic [SQ_W-1:0] sum_sq_q;
  logic [AW-1:0]   sum_abs_q;
  logic [CW-1:0]   err_cnt_q;
  logic [PW-1:0]   max_abs_q;

  // |d|; the top bit is always zero because |d| <= 2^PW - 1
  assign neg_w     = -d;
  assign mag_w     = d[DW-1] ? neg_w : $unsigned(d);
  assign mag_ext_w = SQ_W'(mag_w);

  // Accumulate one error sample per valid cycle; clear wins over accumulate
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum_sq_q  <= '0;
      sum_abs_q <= '0;
      err_cnt_q <= '0;
      max_abs_q <= '0;
    end else if (valid) begin
      sum_sq_q  <= sum_sq_q + mag_ext_w * mag_ext_w;
      sum_abs_q <= sum_abs_q + AW'(mag_w);
      if (mag_w != '0) begin
        err_cnt_q <= err_cnt_q + CW'(1);
      end
      if (mag_w > {1'b0, max_abs_q}) begin
        max_abs_q <= mag_w[PW-1:0];
      end
    end
  end

`ifdef MULT_ERR_WCE_CAPTURE_EN
  logic [WA-1:0] wce_a_q;
  logic [WB-1:0] wce_b_q;

  // Strict increase only, so ties keep the earliest pair
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wce_a_q <= '0;
      wce_b_q <= '0;
    end else if (valid && (mag_w > {1'b0, max_abs_q})) begin
      wce_a_q <= pair_a;
      wce_b_q <= pair_b;
    end
  end

  assign wce_a = wce_a_q;
  assign wce_b = wce_b_q;
`endif

  assign sum_sq  = sum_sq_q;
  assign sum_abs = sum_abs_q;
  assign err_cnt = err_cnt_q;
  assign max_abs = max_abs_q;

endmodule
`default_nettype wire

// File: rtl/mult_err_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_err_sweeper                                           |
// | Description : Drives an attached approximate multiplier through every    |
// |               operand pair, aligns the exact product with the returned   |
// |               product through a LAT-deep pipe and accumulates error      |
// |               statistics. Optional macro MULT_ERR_WCE_CAPTURE_EN adds    |
// |               worst-case operand capture outputs wce_a / wce_b.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mult_err_sweeper
  import mult_err_pkg::*;
#(
  parameter int WA   = 8,
  parameter int WB   = 8,
  parameter int LAT  = 1,
  parameter int SQ_W = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [WA-1:0]        mult_a,
  output logic [WB-1:0]        mult_b,
  input  logic [WA+WB-1:0]     mult_p,
  output logic [SQ_W-1:0]      sum_sq,
  output logic [WA+WB+16:0]    sum_abs,
  output logic [WA+WB:0]       err_cnt,
`ifdef MULT_ERR_WCE_CAPTURE_EN
  output logic [WA-1:0]        wce_a,
  output logic [WB-1:0]        wce_b,
`endif
  output logic [WA+WB-1:0]     max_abs
);

  localparam int            PW         = prod_w(WA, WB);
  localparam int            DW         = diff_w(WA, WB);
  localparam logic [PW-1:0] LAST_PAIR  = PW'(sweep_len(WA, WB) - 64'd1);
  localparam logic [1:0]    DRAIN_LAST = 2'(LAT - 1);

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        pair_q, pair_d;
  logic [1:0]           drain_q, drain_d;
  logic                 done_q;
  logic                 issue_d;
  logic                 clr;
  logic                 flush;
  logic [PW-1:0]        exact_d;
  logic                 vld_q [LAT];
  logic [PW-1:0]        ex_q  [LAT];
  logic signed [DW-1:0] diff;

  // Next-state logic: sweep {A,B} as one counter, B in the low bits
  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    drain_d = drain_q;
    issue_d = 1'b0;
    clr     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pair_d  = '0;
          issue_d = 1'b1;
          clr     = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (pair_q == LAST_PAIR) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          pair_d  = pair_q + PW'(1);
          issue_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer registers; done is registered off the DONE state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pair_q  <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      drain_q <= drain_d;
      done_q  <= (state_q == S_DONE);
    end
  end

  // Exact product of the pair being loaded, so stage 0 lines up with mult_a/b
  assign exact_d = PW'(pair_d[PW-1:WB]) * PW'(pair_d[WB-1:0]);

  // Exact-product pipe; stage LAT-1 lines up with a valid mult_p
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
      end
    end else begin
      vld_q[0] <= issue_d;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
    ex_q[0] <= exact_d;
    for (int i = 1; i < LAT; i++) begin
      ex_q[i] <= ex_q[i-1];
    end
  end

  assign diff = $signed({1'b0, mult_p}) - $signed({1'b0, ex_q[LAT-1]});

`ifdef MULT_ERR_WCE_CAPTURE_EN
  logic [PW-1:0] pr_q [LAT];

  // Operand pair travels alongside its exact product
  always_ff @(posedge clk) begin
    pr_q[0] <= pair_d;
    for (int i = 1; i < LAT; i++) begin
      pr_q[i] <= pr_q[i-1];
    end
  end
`endif

  mult_err_accum #(
    .WA   (WA),
    .WB   (WB),
    .SQ_W (SQ_W)
  ) u_accum (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .valid   (vld_q[LAT-1]),
    .d       (diff),
`ifdef MULT_ERR_WCE_CAPTURE_EN
    .pair_a  (pr_q[LAT-1][PW-1:WB]),
    .pair_b  (pr_q[LAT-1][WB-1:0]),
    .wce_a   (wce_a),
    .wce_b   (wce_b),
`endif
    .sum_sq  (sum_sq),
    .sum_abs (sum_abs),
    .err_cnt (err_cnt),
    .max_abs (max_abs)
  );

  assign busy   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done   = done_q;
  assign mult_a = pair_q[PW-1:WB];
  assign mult_b = pair_q[WB-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mult_err_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mult_err_sweeper                                        |
// | Description : Self-checking bench. Four sweepers run side by side: exact |
// |               (LAT=1), exact+1, constant zero, and a two-stage registered|
// |               exact multiplier (LAT=3). Then abort/restart/reset on the  |
// |               zero-product instance.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mult_err_sweeper;

  logic clk = 1'b0;
  logic rst, start, abort;

  always #5 clk = ~clk;

  logic        busy_a [4];
  logic        done_a [4];
  logic [7:0]  ma_a   [4];
  logic [7:0]  mb_a   [4];
  logic [15:0] p_a    [4];
  logic [47:0] sq_a   [4];
  logic [32:0] abs_a  [4];
  logic [16:0] cnt_a  [4];
  logic [15:0] max_a  [4];
`ifdef MULT_ERR_WCE_CAPTURE_EN
  logic [7:0]  wa_a   [4];
  logic [7:0]  wb_a   [4];
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int L = (gi == 3) ? 3 : 1;
    logic [15:0] exact;
    assign exact = 16'(ma_a[gi]) * 16'(mb_a[gi]);

    if (gi == 3) begin : g_reg
      logic [15:0] r1, r2;
      always @(posedge clk) begin
        r1 <= exact;
        r2 <= r1;
      end
      assign p_a[gi] = r2;
    end else begin : g_comb
      assign p_a[gi] = (gi == 1) ? exact + 16'd1 : (gi == 2) ? 16'd0 : exact;
    end

    mult_err_sweeper #(
      .WA(8), .WB(8), .LAT(L), .SQ_W(48)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .busy    (busy_a[gi]),
      .done    (done_a[gi]),
      .mult_a  (ma_a[gi]),
      .mult_b  (mb_a[gi]),
      .mult_p  (p_a[gi]),
      .sum_sq  (sq_a[gi]),
      .sum_abs (abs_a[gi]),
      .err_cnt (cnt_a[gi]),
`ifdef MULT_ERR_WCE_CAPTURE_EN
      .wce_a   (wa_a[gi]),
      .wce_b   (wb_a[gi]),
`endif
      .max_abs (max_a[gi])
    );
  end

  typedef struct {
    logic [63:0] cnt;
    logic [63:0] sabs;
    logic [63:0] ssq;
    logic [63:0] mx;
    logic [7:0]  wa;
    logic [7:0]  wb;
    int          done_n;
  } vec_t;

  vec_t tbl [4];
  int   done_at  [4];
  int   done_cnt [4];
  int   n_checks = 0;
  int   n_errors = 0;
  int   idle_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int i);
    chk($sformatf("dut%0d reset busy", i),    64'(busy_a[i]), 64'd0);
    chk($sformatf("dut%0d reset done", i),    64'(done_a[i]), 64'd0);
    chk($sformatf("dut%0d reset mult_a", i),  64'(ma_a[i]),   64'd0);
    chk($sformatf("dut%0d reset mult_b", i),  64'(mb_a[i]),   64'd0);
    chk($sformatf("dut%0d reset sum_sq", i),  64'(sq_a[i]),   64'd0);
    chk($sformatf("dut%0d reset sum_abs", i), 64'(abs_a[i]),  64'd0);
    chk($sformatf("dut%0d reset err_cnt", i), 64'(cnt_a[i]),  64'd0);
    chk($sformatf("dut%0d reset max_abs", i), 64'(max_a[i]),  64'd0);
`ifdef MULT_ERR_WCE_CAPTURE_EN
    chk($sformatf("dut%0d reset wce_a", i),   64'(wa_a[i]),   64'd0);
    chk($sformatf("dut%0d reset wce_b", i),   64'(wb_a[i]),   64'd0);
`endif
  endtask

  initial begin
    // Expected full-sweep results, hand-derived
    tbl[0] = '{cnt: 64'd0,     sabs: 64'd0,          ssq: 64'd0,
               mx: 64'd0,      wa: 8'd0,   wb: 8'd0,   done_n: 65538};
    tbl[1] = '{cnt: 64'd65536, sabs: 64'd65536,      ssq: 64'd65536,
               mx: 64'd1,      wa: 8'd0,   wb: 8'd0,   done_n: 65538};
    tbl[2] = '{cnt: 64'd65025, sabs: 64'd1065369600, ssq: 64'd30910041702400,
               mx: 64'd65025,  wa: 8'd255, wb: 8'd255, done_n: 65538};
    tbl[3] = '{cnt: 64'd0,     sabs: 64'd0,          ssq: 64'd0,
               mx: 64'd0,      wa: 8'd0,   wb: 8'd0,   done_n: 65540};

    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_reset(i);
      done_at[i]  = 0;
      done_cnt[i] = 0;
    end

    // Full sweep on all four instances at once
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dut0 busy after start", 64'(busy_a[0]), 64'd1);
    chk("dut0 first pair", 64'({ma_a[0], mb_a[0]}), 64'd0);

    for (int n = 1; n <= 65545; n++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (done_a[i]) begin
          done_cnt[i]++;
          if (done_at[i] == 0) done_at[i] = n;
        end
      end
      if (n == 499) start = 1'b1;
      if (n == 500) start = 1'b0;
      if (n == 600) begin
        chk("dut0 pair after ignored start", 64'({ma_a[0], mb_a[0]}), 64'd600);
        chk("dut3 pair after ignored start", 64'({ma_a[3], mb_a[3]}), 64'd600);
        chk("dut0 busy mid run", 64'(busy_a[0]), 64'd1);
      end
    end

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dut%0d done cycle", i),   64'(done_at[i]),  64'(tbl[i].done_n));
      chk($sformatf("dut%0d done pulses", i),  64'(done_cnt[i]), 64'd1);
      chk($sformatf("dut%0d err_cnt", i),      64'(cnt_a[i]),    tbl[i].cnt);
      chk($sformatf("dut%0d sum_abs", i),      64'(abs_a[i]),    tbl[i].sabs);
      chk($sformatf("dut%0d sum_sq", i),       64'(sq_a[i]),     tbl[i].ssq);
      chk($sformatf("dut%0d max_abs", i),      64'(max_a[i]),    tbl[i].mx);
      chk($sformatf("dut%0d busy after", i),   64'(busy_a[i]),   64'd0);
`ifdef MULT_ERR_WCE_CAPTURE_EN
      chk($sformatf("dut%0d wce_a", i),        64'(wa_a[i]),     64'(tbl[i].wa));
      chk($sformatf("dut%0d wce_b", i),        64'(wb_a[i]),     64'(tbl[i].wb));
`endif
    end

    // Abort at cycle 1000 of a new sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 999; n++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("dut2 busy after abort", 64'(busy_a[2]), 64'd0);
    chk("dut2 done after abort", 64'(done_a[2]), 64'd0);
    idle_done = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (done_a[2]) idle_done++;
    end
    chk("dut2 no done after abort", 64'(idle_done), 64'd0);
    chk("dut2 idle after abort", 64'(busy_a[2]), 64'd0);

    // Restart: cleared sums, pair (0,0)
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dut2 restart busy",    64'(busy_a[2]), 64'd1);
    chk("dut2 restart mult_a",  64'(ma_a[2]),   64'd0);
    chk("dut2 restart mult_b",  64'(mb_a[2]),   64'd0);
    chk("dut2 restart err_cnt", 64'(cnt_a[2]),  64'd0);
    chk("dut2 restart sum_abs", 64'(abs_a[2]),  64'd0);
    chk("dut2 restart sum_sq",  64'(sq_a[2]),   64'd0);
    chk("dut2 restart max_abs", 64'(max_a[2]),  64'd0);

    // Pairs 0..299 accumulated: a=1, b=1..43 are the only nonzero products
    repeat (300) tick();
    chk("dut2 partial err_cnt", 64'(cnt_a[2]), 64'd43);
    chk("dut2 partial sum_abs", 64'(abs_a[2]), 64'd946);
    chk("dut2 partial sum_sq",  64'(sq_a[2]),  64'd27434);
    chk("dut2 partial max_abs", 64'(max_a[2]), 64'd43);
    chk("dut2 partial pair",    64'({ma_a[2], mb_a[2]}), 64'd300);
`ifdef MULT_ERR_WCE_CAPTURE_EN
    chk("dut2 partial wce_a",   64'(wa_a[2]),  64'd1);
    chk("dut2 partial wce_b",   64'(wb_a[2]),  64'd43);
`endif

    // Reset mid-run
    rst = 1'b1;
    tick();
    chk_reset(2);
    rst = 1'b0;
    tick();
    chk("dut2 idle after reset", 64'(busy_a[2]), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
